csk_subtractor_seq: RTL and testbench
=====================================

// Module: csk_subtractor_seq
// PURPOSE
//  Multi-cycle N-bit carry-skip subtractor. Computes diff = a - b - bin one
//  4-bit block per clock, least-significant block first.
//  - Each block uses a 4-bit ripple with a block-level borrow skip.
//  - The block captures a, b and bin on a start pulse and reports completion
//    with a one-cycle done pulse.
//  - Serves as the subtract companion to the 4-bit carry-skip adder in the
//    arithmetic datapath.
// PARAMETERS
//  WIDTH   16   operand width in bits; must be a multiple of 4, minimum 4
//  NBLK    WIDTH/4 (localparam)   number of 4-bit blocks = RUN cycles
// PORTS
//  clk     in   1      rising-edge clock
//  rst_n   in   1      asynchronous active-low reset
//  start   in   1      request; sampled only in IDLE
//  a       in   WIDTH  minuend; captured when start is accepted
//  b       in   WIDTH  subtrahend; captured when start is accepted
//  bin     in   1      borrow-in; captured when start is accepted
//  busy    out  1      high while an operation is in progress
//  done    out  1      one-cycle pulse when diff/bout become valid
//  diff    out  WIDTH  difference, held until the next accepted start
//  bout    out  1      borrow-out of the MSB block (1 = a < b + bin, unsigned)
//  ovf     out  1      signed overflow; present only with CSK_SUB_OVF_EN
// BEHAVIOUR
//  Reset
//   - rst_n low clears state to IDLE immediately, independent of clk.
//   - Clears busy, done, diff, bout, ovf, the block index and the internal
//     borrow.
//   - Reset mid-operation abandons the operation; no done pulse is issued.
//  States
//   - IDLE: start=1 -> RUN, latches a, b, bin; idx <= 0; busy <= 1;
//     done <= 0.
//   - RUN: on each edge, process block idx, write diff[4*idx+3:4*idx],
//     idx <= idx+1.
//   - On the edge that processes block NBLK-1: state -> IDLE, busy <= 0,
//     done <= 1, bout <= final borrow.
//   - done stays high for exactly one cycle, then returns to 0.
//  Latency
//   - start accepted at edge k.
//   - done is high during the cycle after edge k+NBLK.
//   - Back-to-back operation: start may be accepted in the same cycle that
//     done is high, because state is already IDLE.
//  Block arithmetic (carry form, c = ~borrow)
//   - Per bit: p_i = a_i ^ ~b_i; s_i = p_i ^ c_i;
//     c_{i+1} = (a_i & ~b_i) | (p_i & c_i).
//   - Block propagate P = &p[3:0].
//   - Block carry out = P ? c_in : ripple c4. Next block borrow = ~(block
//     carry out).
//   - First block carry-in = ~bin.
//   - The result must equal (a - b - bin) mod 2^WIDTH for all inputs.
//  Boundary conditions
//   - start while busy is ignored; latched operands are unchanged.
//   - a == b with bin=1: every block takes the skip path;
//     result is all-ones with bout=1.
//   - WIDTH == 4: single RUN cycle; done is high one cycle after the start
//     edge.
//   - Input changes after start acceptance have no effect on the result.
// CONFIGURATION
//  CSK_SUB_OVF_EN
//   - Defined: port ovf exists and is registered with done:
//     ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
//   - ovf holds until the next accepted start, which clears it.
//   - Not defined: ovf port and its logic are absent; other behaviour is
//     identical.
// TESTING (WIDTH=16)
//  1. a=0x1234, b=0x0234, bin=0 -> done 4 cycles after start edge;
//     diff=0x1000, bout=0.
//  2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1 (borrow ripples
//     through all blocks).
//  3. a=b=0x5A5A, bin=1 -> diff=0xFFFF, bout=1 (full skip chain);
//     a=b, bin=0 -> 0x0000, bout=0.
//  4. OVF_EN: a=0x8000, b=0x0001 -> diff=0x7FFF, ovf=1;
//     a=0x0005, b=0x0003 -> diff=0x0002, ovf=0.
//  5. start pulsed at cycles 1-3 after acceptance with new operands ->
//     ignored; first result correct, a single done pulse.
//  6. rst_n low during RUN idx=2 -> busy=0, diff=0, no done pulse;
//     a new start after release completes normally.

Source files
------------

// File: rtl/csk_subtractor_seq.sv
// Multi-cycle carry-skip subtractor, one 4-bit block per clock, LSB block first.
// Define CSK_SUB_OVF_EN to add the registered signed-overflow output ovf.
module csk_subtractor_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef CSK_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = WIDTH / 4;
  localparam int IW = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBLK - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             brw;
  logic [IW-1:0]    idx;
  logic [IW+1:0]    base;

  logic [3:0] ba;
  logic [3:0] bb;
  logic [3:0] p;
  logic [3:0] s;
  logic       cy;
  logic       cout;

  assign base = {idx, 2'b00};

  // Ripple in carry form; a fully propagating block skips straight to c_in.
  always_comb begin
    ba = a_q[base +: 4];
    bb = b_q[base +: 4];
    p  = '0;
    s  = '0;
    cy = ~brw;
    for (int i = 0; i < 4; i++) begin
      p[i] = ba[i] ^ ~bb[i];
      s[i] = p[i] ^ cy;
      cy   = (ba[i] & ~bb[i]) | (p[i] & cy);
    end
    cout = (&p) ? ~brw : cy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      brw   <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef CSK_SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            a_q   <= a;
            b_q   <= b;
            brw   <= bin;
            idx   <= '0;
            busy  <= 1'b1;
`ifdef CSK_SUB_OVF_EN
            ovf   <= 1'b0;
`endif
          end
        end
        RUN: begin
          diff[base +: 4] <= s;
          brw <= ~cout;
          idx <= idx + 1'b1;
          if (idx == LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            bout  <= ~cout;
`ifdef CSK_SUB_OVF_EN
            ovf   <= (a_q[WIDTH-1] ^ b_q[WIDTH-1])
                   & (s[3] ^ a_q[WIDTH-1]);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csk_subtractor_seq.sv
// Bench for csk_subtractor_seq: arithmetic reference model plus
// directed literal cases and randomized back-to-back operations.
module tb_csk_subtractor_seq;

  localparam int W = 16;
  localparam int NBLK = W / 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef CSK_SUB_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  csk_subtractor_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef CSK_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Reference: plain (W+1)-bit arithmetic; top bit is the borrow.
  function automatic logic [W:0] ref_sub(input logic [W-1:0] x,
                                         input logic [W-1:0] y,
                                         input logic c);
    return {1'b0, x} - {1'b0, y} - {{W{1'b0}}, c};
  endfunction

  bit           m_busy = 0;
  bit           m_done = 0;
  bit           m_bout = 0;
  bit           m_ovf = 0;
  logic [W-1:0] m_diff = '0;
  bit           p_bout = 0;
  bit           p_ovf = 0;
  logic [W-1:0] p_diff = '0;
  int           rem = 0;
  logic [W:0]   r;

  // Transaction model: accept when idle, result appears NBLK edges later.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0;
      m_done = 0;
      m_bout = 0;
      m_ovf  = 0;
      m_diff = '0;
      rem    = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        rem--;
        if (rem == 0) begin
          m_busy = 0;
          m_done = 1;
          m_diff = p_diff;
          m_bout = p_bout;
          m_ovf  = p_ovf;
        end
      end else if (start) begin
        r      = ref_sub(a, b, bin);
        p_diff = r[W-1:0];
        p_bout = r[W];
        p_ovf  = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        m_busy = 1;
        m_ovf  = 0;
        rem    = NBLK;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      if (!m_busy) begin
        chk("diff", diff, m_diff);
        chk("bout", bout, m_bout);
`ifdef CSK_SUB_OVF_EN
        chk("ovf", ovf, m_ovf);
`endif
      end
    end
  end

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic c, input bit hammer);
    int lat;
    a = x;
    b = y;
    bin = c;
    start = 1'b1;
    @(negedge clk);
    lat = 0;
    if (hammer) begin
      a = ~x;
      b = x ^ y;
      bin = ~c;
      repeat (3) @(negedge clk);
      lat = 3;
    end
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    bin = 1'($urandom);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, NBLK);
  endtask

  logic [W-1:0] x;
  logic [W-1:0] y;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'h1234, 16'h0234, 1'b0, 0);
    chk("t1_diff", diff, 16'h1000);
    chk("t1_bout", bout, 0);

    do_op(16'h0000, 16'h0001, 1'b0, 0);
    chk("t2_diff", diff, 16'hFFFF);
    chk("t2_bout", bout, 1);

    do_op(16'h5A5A, 16'h5A5A, 1'b1, 0);
    chk("t3a_diff", diff, 16'hFFFF);
    chk("t3a_bout", bout, 1);
    do_op(16'h5A5A, 16'h5A5A, 1'b0, 0);
    chk("t3b_diff", diff, 16'h0000);
    chk("t3b_bout", bout, 0);

    do_op(16'h8000, 16'h0001, 1'b0, 0);
    chk("t4a_diff", diff, 16'h7FFF);
`ifdef CSK_SUB_OVF_EN
    chk("t4a_ovf", ovf, 1);
`endif
    do_op(16'h0005, 16'h0003, 1'b0, 0);
    chk("t4b_diff", diff, 16'h0002);
`ifdef CSK_SUB_OVF_EN
    chk("t4b_ovf", ovf, 0);
`endif

    do_op(16'hABCD, 16'h1234, 1'b1, 1);
    chk("t5_diff", diff, 16'h9998);
    chk("t5_bout", bout, 0);

    a = 16'h0003;
    b = 16'h0005;
    bin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_diff", diff, 0);
    chk("t6_bout", bout, 0);
    repeat (2) begin
      @(negedge clk);
      chk("t6_done", done, 0);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    do_op(16'h0003, 16'h0005, 1'b0, 0);
    chk("t6_diff2", diff, 16'hFFFE);
    chk("t6_bout2", bout, 1);

    for (int i = 0; i < 300; i++) begin
      x = W'($urandom);
      y = ($urandom_range(0, 7) == 0) ? x : W'($urandom);
      do_op(x, y, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
